// File: rtl/mdu_pkg.sv
// Shared opcodes, op/state enums and helpers for the HI/LO multiply-divide unit.
// Used by mult_div_unit and mdu_div_core.
package mdu_pkg;

    localparam logic [1:0] OPC_MULT  = 2'b00;
    localparam logic [1:0] OPC_MULTU = 2'b01;
    localparam logic [1:0] OPC_DIV   = 2'b10;
    localparam logic [1:0] OPC_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        OP_MULT  = OPC_MULT,
        OP_MULTU = OPC_MULTU,
        OP_DIV   = OPC_DIV,
        OP_DIVU  = OPC_DIVU
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic is_div(op_e o);
        return o[1];
    endfunction

    function automatic logic is_signed(op_e o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on operand magnitudes, one quotient bit per step.
// Holds divisor, partial remainder and the shifting dividend/quotient.
import mdu_pkg::*;

module mdu_div_core #(
    parameter int Dbits = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [Dbits-1:0] dividend,
    input  logic [Dbits-1:0] divisor,
    output logic [Dbits-1:0] quotient,
    output logic [Dbits-1:0] remainder
);

    logic [Dbits-1:0] rem;
    logic [Dbits-1:0] quo;
    logic [Dbits-1:0] dvs;
    logic [Dbits:0]   shifted;
    logic [Dbits-1:0] diff;
    logic             borrow;

    assign shifted = {rem, quo[Dbits-1]};
    assign borrow  = shifted < {1'b0, dvs};
    // Modular difference is exact whenever no borrow occurs
    assign diff    = shifted[Dbits-1:0] - dvs;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (step) begin
            if (!borrow) begin
                rem <= diff;
                quo <= {quo[Dbits-2:0], 1'b1};
            end else begin
                rem <= shifted[Dbits-1:0];
                quo <= {quo[Dbits-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// The divider is built only when MDU_DIV_EN is defined.
import mdu_pkg::*;

module mult_div_unit #(
    parameter int Dbits = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [Dbits-1:0] srcA,
    input  logic [Dbits-1:0] srcB,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [Dbits-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [Dbits-1:0] hi,
    output logic [Dbits-1:0] lo,
    output logic             div0
);

    localparam int            CW   = $clog2(Dbits);
    localparam logic [CW-1:0] LAST = CW'(Dbits - 1);

    state_e             state, state_nx;
    op_e                op_in, op_q;
    logic               accept, sgn_in, sa, sb;
    logic [Dbits-1:0]   a_abs, b_abs, a_mag;
    logic [Dbits-1:0]   p_hi, p_lo, fix_hi, fix_lo;
    logic [Dbits-1:0]   hi_q, lo_q;
    logic [Dbits:0]     mul_sum;
    logic [2*Dbits-1:0] prod, prod_fix;
    logic [CW-1:0]      cnt;
    logic               neg_p, done_q;

    assign op_in  = op_e'(op);
    assign accept = (state == S_IDLE) && start;
    assign sgn_in = is_signed(op_in);
    assign sa     = sgn_in & srcA[Dbits-1];
    assign sb     = sgn_in & srcB[Dbits-1];
    assign a_abs  = sa ? ~srcA + 1'b1 : srcA;
    assign b_abs  = sb ? ~srcB + 1'b1 : srcB;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
`ifdef MDU_DIV_EN
                    state_nx = S_RUN;
`else
                    // No divider: divides skip straight to completion
                    state_nx = is_div(op_in) ? S_FIX : S_RUN;
`endif
                end
            end
            S_RUN:   if (cnt == LAST) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_mag} : '0);
    assign prod    = {p_hi, p_lo};

`ifdef MDU_DIV_EN
    logic [Dbits-1:0] a_raw, quo, rem;
    logic             neg_r, b_zero, div0_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_raw  <= '0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
        end else if (accept) begin
            a_raw  <= srcA;
            neg_r  <= sa;
            b_zero <= (srcB == '0);
        end
    end

    mdu_div_core #(.Dbits(Dbits)) u_div (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (accept && is_div(op_in)),
        .step      ((state == S_RUN) && is_div(op_q)),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            div0_q <= 1'b0;
        else if ((state == S_DONE) && is_div(op_q))
            div0_q <= b_zero;
    end

    assign div0 = div0_q;
`else
    assign div0 = 1'b0;
`endif

    always_comb begin
        prod_fix = neg_p ? ~prod + 1'b1 : prod;
        fix_hi   = prod_fix[2*Dbits-1:Dbits];
        fix_lo   = prod_fix[Dbits-1:0];
`ifdef MDU_DIV_EN
        if (is_div(op_q)) begin
            if (b_zero) begin
                fix_lo = '1;
                fix_hi = a_raw;
            end else begin
                fix_lo = neg_p ? ~quo + 1'b1 : quo;
                fix_hi = neg_r ? ~rem + 1'b1 : rem;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= OP_MULT;
            a_mag <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            cnt   <= '0;
            neg_p <= 1'b0;
        end else if (accept) begin
            op_q  <= op_in;
            a_mag <= a_abs;
            p_hi  <= '0;
            p_lo  <= b_abs;
            cnt   <= '0;
            neg_p <= sa ^ sb;
        end else if (state == S_RUN) begin
            cnt <= cnt + 1'b1;
            if (!is_div(op_q))
                {p_hi, p_lo} <= {mul_sum, p_lo[Dbits-1:1]};
        end else if (state == S_FIX) begin
            // Product/quotient regs reused to hold the corrected result
            p_hi <= fix_hi;
            p_lo <= fix_lo;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == S_DONE);
            if (state == S_DONE) begin
`ifdef MDU_DIV_EN
                hi_q <= p_hi;
                lo_q <= p_lo;
`else
                if (!is_div(op_q)) begin
                    hi_q <= p_hi;
                    lo_q <= p_lo;
                end
`endif
            end else if ((state == S_IDLE) && !start) begin
                if (mthi) hi_q <= wdata;
                if (mtlo) lo_q <= wdata;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops, moves, busy and reset.
// Expects divide results when MDU_DIV_EN is defined, no-divider behaviour otherwise.
module tb_mult_div_unit;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        int          lat;
        int          acc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    exp_t        sb[$];
    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;
    logic        prev_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_div0 = 1'b0;

    mult_div_unit #(.Dbits(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .div0    (div0)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clock) begin
        if (done) begin
            check("done_one_cycle", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("div0", 64'(div0), 64'(e.div0));
                check("latency", 64'(cyc - e.acc), 64'(e.lat));
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
        prev_done <= done;
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh,
                          input logic [31:0] el, input logic ed,
                          input logic mh, input logic ml,
                          input logic [31:0] wd);
        exp_t e;
        @(negedge clock);
        e.lat = 34;
        if (o[1] && !DIV_EN) begin
            eh = m_hi;
            el = m_lo;
            ed = 1'b0;
            e.lat = 2;
        end
        if (o[1]) m_div0 = ed;
        m_hi = eh;
        m_lo = el;
        e.hi = eh;
        e.lo = el;
        e.div0 = m_div0;
        start = 1'b1;
        op = o;
        srcA = a;
        srcB = b;
        mthi = mh;
        mtlo = ml;
        wdata = wd;
        @(posedge clock);
        #1;
        e.acc = cyc;
        sb.push_back(e);
        start = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            failed++;
            $display("FAIL timeout_%s: still busy, expected done", name);
            sb.delete();
        end
    endtask

    task automatic op_done(input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh,
                           input logic [31:0] el, input logic ed,
                           input string name);
        launch(o, a, b, eh, el, ed, 1'b0, 1'b0, 32'h0);
        wait_done(name);
    endtask

    initial begin
        logic [31:0] old_hi;

        repeat (3) @(posedge clock);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        #1 reset_n = 1'b1;

        op_done(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
        op_done(2'b00, 32'hFFFFFFFD, 32'd7,
                32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg");
        op_done(2'b00, 32'h80000000, 32'h80000000,
                32'h40000000, 32'h00000000, 1'b0, "mult_intmin");
        op_done(2'b10, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg");
        op_done(2'b11, 32'd100, 32'd7,
                32'd2, 32'd14, 1'b0, "divu");
        op_done(2'b10, 32'h80000000, 32'hFFFFFFFF,
                32'h00000000, 32'h80000000, 1'b0, "div_intmin");
        op_done(2'b11, 32'd5, 32'd0,
                32'd5, 32'hFFFFFFFF, 1'b1, "divu_zero");
        check("div0_sticky", 64'(div0), 64'(m_div0));
        op_done(2'b11, 32'd9, 32'd3,
                32'd0, 32'd3, 1'b0, "divu_clear");
        check("div0_cleared", 64'(div0), 64'd0);

        // Start and mthi while busy must be dropped
        old_hi = m_hi;
        launch(2'b01, 32'h00010000, 32'h00010000,
               32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        check("busy_mid", 64'(busy), 64'd1);
        check("hold_hi", 64'(hi), 64'(old_hi));
        start = 1'b1;
        op = 2'b00;
        srcA = 32'd2;
        srcB = 32'd2;
        mthi = 1'b1;
        wdata = 32'h1234;
        @(posedge clock);
        #1;
        start = 1'b0;
        mthi = 1'b0;
        wait_done("busy_ignore");
        repeat (3) @(negedge clock);
        check("no_requeue", 64'(hi), 64'h1);

        @(negedge clock);
        mtlo = 1'b1;
        wdata = 32'hABCD;
        @(posedge clock);
        #1;
        mtlo = 1'b0;
        check("mtlo_lo", 64'(lo), 64'hABCD);
        check("mtlo_hi", 64'(hi), 64'h1);

        @(negedge clock);
        mthi = 1'b1;
        mtlo = 1'b1;
        wdata = 32'h55;
        @(posedge clock);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthilo_hi", 64'(hi), 64'h55);
        check("mthilo_lo", 64'(lo), 64'h55);

        // Start wins over simultaneous moves
        launch(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0,
               1'b1, 1'b1, 32'h99);
        wait_done("start_vs_move");

        // Reset mid-operation
        launch(2'b00, 32'hFFFFFFFD, 32'd7,
               32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_div0", 64'(div0), 64'd0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        m_div0 = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        op_done(2'b00, 32'hFFFFFFFD, 32'd7,
                32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "after_reset");

        repeat (40) @(negedge clock);
        check("queue_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
